// File: rtl/image_pad_loader_if.sv
// Bundle of signals between a pixel producer / image consumer and the
// image_pad_loader.
//
// Handshake rule: a pixel beat transfers on a clk edge where in_valid and
// in_ready are both 1. in_sof and in_pixel are only meaningful on that beat.
// image_padded is meaningful only while image_valid is 1. The consumer
// releases the image by raising image_ack while image_valid is 1.
//
// Signals:
//   in_pixel      signed pixel data (producer -> loader)
//   in_valid      pixel valid (producer -> loader)
//   in_sof        start of frame, qualifies the pixel on the same beat
//   in_ready      loader can accept a pixel (loader -> producer)
//   image_padded  [row][col] padded image with zero border (loader -> consumer)
//   image_valid   image_padded is complete and stable (loader -> consumer)
//   image_ack     consumer is done with the image (consumer -> loader)
//   frame_done    one-cycle pulse when a frame completes
//   frame_err     one-cycle pulse when in_sof arrives mid-frame
//   dbg_state     loader FSM state: 0 = LOAD, 1 = FULL
interface image_pad_loader_if #(
    parameter int bitwidth = 16,
    parameter int IMG      = 28,
    parameter int PAD      = 2
);
    localparam int N = IMG + 2 * PAD;

    logic signed [bitwidth-1:0] in_pixel;
    logic                       in_valid;
    logic                       in_sof;
    logic                       in_ready;
    logic signed [bitwidth-1:0] image_padded [N][N];
    logic                       image_valid;
    logic                       image_ack;
    logic                       frame_done;
    logic                       frame_err;
    logic                       dbg_state;

    // Producer/consumer side.
    modport master (
        output in_pixel, in_valid, in_sof, image_ack,
        input  in_ready, image_padded, image_valid, frame_done, frame_err, dbg_state
    );

    // Loader side.
    modport slave (
        input  in_pixel, in_valid, in_sof, image_ack,
        output in_ready, image_padded, image_valid, frame_done, frame_err, dbg_state
    );
endinterface

// File: rtl/image_pad_loader.sv
// image_pad_loader: streaming front end for the first convolution layer.
//
// Accepts an IMG x IMG image one pixel per handshake in row-major order,
// stores it in a register buffer and presents it as an N x N array
// (N = IMG + 2*PAD) with a permanent zero border. Once the last pixel lands
// the image is held (FULL) until the consumer acknowledges it, then the
// loader returns to LOAD for the next frame.
//
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  image_pad_loader_if.slave (pixel stream in, padded image out)
module image_pad_loader #(
    parameter int bitwidth = 16,
    parameter int IMG      = 28,
    parameter int PAD      = 2
) (
    input logic            clk,
    input logic            rst,
    image_pad_loader_if.slave bus
);
    localparam int                CW   = (IMG > 1) ? $clog2(IMG) : 1;
    localparam logic [CW-1:0]     LAST = CW'(IMG - 1);

    typedef enum logic {
        LOAD = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t                     state;
    logic [CW-1:0]              row;
    logic [CW-1:0]              col;
    // Only the interior is stored; the border is a constant zero.
    logic signed [bitwidth-1:0] pix [IMG][IMG];
    logic                       accept;

    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.dbg_state = (state == FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= LOAD;
            row             <= '0;
            col             <= '0;
            bus.in_ready    <= 1'b1;
            bus.image_valid <= 1'b0;
            bus.frame_done  <= 1'b0;
            bus.frame_err   <= 1'b0;
            for (int r = 0; r < IMG; r++) begin
                for (int c = 0; c < IMG; c++) begin
                    pix[r][c] <= '0;
                end
            end
        end else begin
            bus.frame_done <= 1'b0;
            bus.frame_err  <= 1'b0;
            case (state)
                LOAD: begin
                    if (accept) begin
                        if (bus.in_sof) begin
                            // Start of frame always lands at the first
                            // interior position; a partial frame is dropped.
                            pix[0][0] <= bus.in_pixel;
                            row       <= '0;
                            col       <= CW'(1);
                            if (row != '0 || col != '0) begin
                                bus.frame_err <= 1'b1;
                            end
                        end else begin
                            pix[row][col] <= bus.in_pixel;
                            if (row == LAST && col == LAST) begin
                                row             <= '0;
                                col             <= '0;
                                state           <= FULL;
                                bus.in_ready    <= 1'b0;
                                bus.image_valid <= 1'b1;
                                bus.frame_done  <= 1'b1;
                            end else if (col == LAST) begin
                                col <= '0;
                                row <= row + CW'(1);
                            end else begin
                                col <= col + CW'(1);
                            end
                        end
                    end
                end
                FULL: begin
                    if (bus.image_ack) begin
                        state           <= LOAD;
                        bus.in_ready    <= 1'b1;
                        bus.image_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

    // Combinational view of the buffer: zero border around the interior.
    always_comb begin
        for (int r = 0; r < IMG + 2 * PAD; r++) begin
            for (int c = 0; c < IMG + 2 * PAD; c++) begin
                bus.image_padded[r][c] = '0;
            end
        end
        for (int r = 0; r < IMG; r++) begin
            for (int c = 0; c < IMG; c++) begin
                bus.image_padded[r + PAD][c + PAD] = pix[r][c];
            end
        end
    end
endmodule

// File: tb/tb_image_pad_loader.sv
// Self-checking bench for image_pad_loader: a reference model tracks where
// each accepted pixel must land, pushes it to an expected queue, and the
// queue is drained against image_padded when the frame completes.
module tb_image_pad_loader;
    localparam int BW   = 16;
    localparam int IMG  = 28;
    localparam int PAD  = 2;
    localparam int N    = IMG + 2 * PAD;
    localparam int NPIX = IMG * IMG;

    typedef struct {
        int            r;
        int            c;
        logic [BW-1:0] v;
    } exp_t;

    // Clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    image_pad_loader_if #(.bitwidth(BW), .IMG(IMG), .PAD(PAD)) bus();

    image_pad_loader #(.bitwidth(BW), .IMG(IMG), .PAD(PAD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Scoreboard state
    exp_t          exp_q[$];
    logic [BW-1:0] exp_img [N][N];
    int            k = 0;
    int            n_checks = 0;
    int            n_err = 0;
    int            done_cnt = 0;
    int            err_cnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.frame_done) done_cnt++;
            if (bus.frame_err) err_cnt++;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        k = 0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                exp_img[r][c] = '0;
    endtask

    task automatic model_accept(input logic [BW-1:0] v, input logic sof);
        exp_t e;
        if (sof) begin
            exp_q.delete();
            k = 0;
        end
        e.r = k / IMG + PAD;
        e.c = k % IMG + PAD;
        e.v = v;
        exp_q.push_back(e);
        exp_img[e.r][e.c] = v;
        k++;
        if (k == NPIX) k = 0;
    endtask

    // Driver: optional idle gap, then one beat held until it is taken.
    task automatic drive_beat(input logic [BW-1:0] v, input logic sof, input int gap);
        int t = 0;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_sof   = 1'b0;
        end
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_pixel = v;
        bus.in_sof   = sof;
        while (bus.in_ready !== 1'b1 && t < 16) begin
            @(negedge clk);
            t++;
        end
        if (t == 16) check_val("ready_timeout", 32'(bus.in_ready), 1);
        @(posedge clk);
        model_accept(v, sof);
    endtask

    // mode 0: r*IMG+c+1, mode 1: random, mode 2: random with 0x8000/0xFFFF at k=5/6
    task automatic send_pixels(input int count, input int mode, input int gap_max, input logic first_sof);
        logic [BW-1:0] v;
        for (int i = 0; i < count; i++) begin
            if (mode == 0) v = BW'(k + 1);
            else if (mode == 2 && k == 5) v = 16'h8000;
            else if (mode == 2 && k == 6) v = 16'hFFFF;
            else v = BW'($urandom);
            drive_beat(v, first_sof && (i == 0), $urandom_range(0, gap_max));
        end
    endtask

    task automatic check_image_model(input string tag);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                check_val(tag, 32'($unsigned(bus.image_padded[r][c])), 32'(exp_img[r][c]));
    endtask

    // Called right after the last beat of a frame has been accepted.
    task automatic end_frame_checks(input string tag);
        exp_t e;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        check_val({tag, "_done_pulse"}, 32'(bus.frame_done), 1);
        check_val({tag, "_valid"}, 32'(bus.image_valid), 1);
        check_val({tag, "_ready_low"}, 32'(bus.in_ready), 0);
        check_val({tag, "_state_full"}, 32'(bus.dbg_state), 1);
        @(negedge clk);
        check_val({tag, "_done_one_cycle"}, 32'(bus.frame_done), 0);
        check_val({tag, "_valid_held"}, 32'(bus.image_valid), 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val({tag, "_pix"}, 32'($unsigned(bus.image_padded[e.r][e.c])), 32'(e.v));
        end
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                if (r < PAD || r >= PAD + IMG || c < PAD || c >= PAD + IMG)
                    check_val({tag, "_border"}, 32'($unsigned(bus.image_padded[r][c])), 0);
    endtask

    task automatic ack_image();
        @(negedge clk);
        bus.image_ack = 1'b1;
        @(negedge clk);
        bus.image_ack = 1'b0;
        check_val("ack_ready", 32'(bus.in_ready), 1);
        check_val("ack_valid_low", 32'(bus.image_valid), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int done_before;
        int err_before;
        bus.in_valid  = 1'b0;
        bus.in_pixel  = '0;
        bus.in_sof    = 1'b0;
        bus.image_ack = 1'b0;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_val("rst_ready", 32'(bus.in_ready), 1);
        check_val("rst_valid", 32'(bus.image_valid), 0);
        check_val("rst_done", 32'(bus.frame_done), 0);
        check_val("rst_err", 32'(bus.frame_err), 0);
        check_val("rst_state", 32'(bus.dbg_state), 0);
        check_image_model("rst_img");

        // Continuous counting frame with SOF
        send_pixels(NPIX, 0, 0, 1'b1);
        end_frame_checks("f1");
        check_val("f1_2_2", 32'($unsigned(bus.image_padded[2][2])), 1);
        check_val("f1_2_29", 32'($unsigned(bus.image_padded[2][29])), 28);
        check_val("f1_29_29", 32'($unsigned(bus.image_padded[29][29])), 784);
        check_val("f1_done_cnt", done_cnt, 1);
        ack_image();

        // Backpressured random frame, then hold in FULL
        send_pixels(NPIX, 1, 3, 1'b1);
        end_frame_checks("f2");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_pixel = 16'h7FFF;
            bus.in_sof   = 1'b0;
            check_val("hold_ready_low", 32'(bus.in_ready), 0);
        end
        check_image_model("hold_img");

        // Ack cycle with a beat offered: taken one cycle later
        @(negedge clk);
        bus.image_ack = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_pixel  = 16'h1234;
        bus.in_sof    = 1'b1;
        check_val("ackcyc_ready_low", 32'(bus.in_ready), 0);
        @(negedge clk);
        bus.image_ack = 1'b0;
        check_val("postack_ready", 32'(bus.in_ready), 1);
        check_val("postack_valid", 32'(bus.image_valid), 0);
        @(posedge clk);
        model_accept(16'h1234, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        check_val("postack_pix", 32'($unsigned(bus.image_padded[2][2])), 32'h1234);

        // Mid-frame SOF after 100 pixels
        err_before = err_cnt;
        send_pixels(99, 1, 0, 1'b0);
        drive_beat(16'h0055, 1'b1, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        check_val("midsof_err_pulse", 32'(bus.frame_err), 1);
        check_val("midsof_pix", 32'($unsigned(bus.image_padded[2][2])), 32'h0055);
        @(negedge clk);
        check_val("midsof_err_one_cycle", 32'(bus.frame_err), 0);
        check_val("midsof_err_cnt", err_cnt, err_before + 1);
        done_before = done_cnt;
        send_pixels(782, 1, 1, 1'b0);
        check_val("midsof_no_early_done", done_cnt, done_before);
        send_pixels(1, 1, 0, 1'b0);
        end_frame_checks("f3");
        ack_image();

        // Reset mid-frame after 300 pixels
        send_pixels(300, 1, 0, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_val("midrst_ready", 32'(bus.in_ready), 1);
        check_val("midrst_valid", 32'(bus.image_valid), 0);
        check_val("midrst_state", 32'(bus.dbg_state), 0);
        check_image_model("midrst_img");
        send_pixels(NPIX, 1, 2, 1'b0);
        end_frame_checks("f4");
        ack_image();

        // Signed extremes, and an ack pulse during LOAD that must be ignored
        done_before = done_cnt;
        send_pixels(400, 2, 0, 1'b0);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.image_ack = 1'b1;
        @(negedge clk);
        bus.image_ack = 1'b0;
        check_val("loadack_ready", 32'(bus.in_ready), 1);
        check_val("loadack_valid", 32'(bus.image_valid), 0);
        check_val("loadack_state", 32'(bus.dbg_state), 0);
        send_pixels(383, 2, 0, 1'b0);
        check_val("loadack_no_early_done", done_cnt, done_before);
        send_pixels(1, 2, 0, 1'b0);
        end_frame_checks("f5");
        check_val("f5_min", 32'($unsigned(bus.image_padded[2][7])), 32'h8000);
        check_val("f5_neg1", 32'($unsigned(bus.image_padded[2][8])), 32'hFFFF);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
